// File: rtl/config_loader.sv
// config_loader: sequences configuration words from a valid/ready stream into
// the configuration latch bank, one registered one-hot enable pulse per word.
// Optional feature macro: CFG_LOADER_CHECKSUM_EN (adds a trailing XOR checksum
// word that is compared against all loaded words and reported on io_error).
module config_loader #(
  parameter int unsigned NUM_WORDS = 28,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned IDX_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_cfg_valid,
  input  logic [WORD_W-1:0]    io_cfg_data,
  output logic                 io_cfg_ready,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic [IDX_W-1:0]     io_word_idx,
  output logic                 io_busy,
  output logic                 io_done,
  output logic                 io_error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4,
`ifdef CFG_LOADER_CHECKSUM_EN
    CHECK  = 3'd5,
`endif
    DONE   = 3'd6
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [IDX_W-1:0]       idx_d;
  logic [WORD_W-1:0]      d_out_d;
  logic [NUM_WORDS-1:0]   en_d;
  logic                   ready_d;
  logic                   busy_d;
  logic                   done_d;
  logic                   xfer;

`ifdef CFG_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0]      acc_q;
  logic [WORD_W-1:0]      acc_d;
  logic                   err_d;
`endif

  // State and registered outputs; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      io_word_idx   <= '0;
      io_d_out      <= '0;
      io_configs_en <= '0;
      io_cfg_ready  <= 1'b0;
      io_busy       <= 1'b0;
      io_done       <= 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
      acc_q         <= '0;
      io_error      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      io_word_idx   <= idx_d;
      io_d_out      <= d_out_d;
      io_configs_en <= en_d;
      io_cfg_ready  <= ready_d;
      io_busy       <= busy_d;
      io_done       <= done_d;
`ifdef CFG_LOADER_CHECKSUM_EN
      acc_q         <= acc_d;
      io_error      <= err_d;
`endif
    end
  end

`ifndef CFG_LOADER_CHECKSUM_EN
  assign io_error = 1'b0;
`endif

  // Next state plus next values of the output registers; io_start overrides all.
  always_comb begin
    state_d = state_q;
    idx_d   = io_word_idx;
    d_out_d = io_d_out;
    xfer    = io_cfg_valid && io_cfg_ready;
`ifdef CFG_LOADER_CHECKSUM_EN
    acc_d   = acc_q;
    err_d   = io_error;
`endif

    if (io_start) begin
      state_d = LOAD;
      idx_d   = '0;
`ifdef CFG_LOADER_CHECKSUM_EN
      acc_d   = '0;
      err_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        LOAD: begin
          if (xfer) begin
            d_out_d = io_cfg_data;
`ifdef CFG_LOADER_CHECKSUM_EN
            acc_d   = acc_q ^ io_cfg_data;
`endif
            state_d = SETUP;
          end
        end
        SETUP: begin
          state_d = STROBE;
        end
        STROBE: begin
          state_d = HOLD;
        end
        HOLD: begin
          if (io_word_idx < LAST_IDX) begin
            idx_d   = io_word_idx + IDX_W'(1);
            state_d = LOAD;
          end else begin
`ifdef CFG_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end
        end
`ifdef CFG_LOADER_CHECKSUM_EN
        CHECK: begin
          // Trailing checksum word is consumed here and never strobed.
          if (xfer) begin
            err_d   = (io_cfg_data != acc_q);
            state_d = DONE;
          end
        end
`endif
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

`ifdef CFG_LOADER_CHECKSUM_EN
    ready_d = (state_d == LOAD) || (state_d == CHECK);
`else
    ready_d = (state_d == LOAD);
`endif
    busy_d  = (state_d != IDLE) && (state_d != DONE);
    done_d  = (state_d == DONE);
    en_d    = (state_d == STROBE) ? (NUM_WORDS'(1) << idx_d) : '0;
  end

endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed self-checking bench for config_loader.
// Honours CFG_LOADER_CHECKSUM_EN when the RTL is built with it.
module tb_config_loader;

  localparam int unsigned NW  = 28;
  localparam int unsigned WW  = 32;
  localparam int unsigned IW  = 5;
`ifdef CFG_LOADER_CHECKSUM_EN
  localparam int unsigned CHK = 1;
`else
  localparam int unsigned CHK = 0;
`endif
  localparam int BUDGET = 400;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_start;
  logic          io_cfg_valid;
  logic [WW-1:0] io_cfg_data;
  logic          io_cfg_ready;
  logic [WW-1:0] io_d_out;
  logic [NW-1:0] io_configs_en;
  logic [IW-1:0] io_word_idx;
  logic          io_busy;
  logic          io_done;
  logic          io_error;

  int passed = 0;
  int total  = 0;

  logic [WW-1:0] words [0:NW];

  config_loader #(.NUM_WORDS(NW), .WORD_W(WW), .IDX_W(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_start      (io_start),
    .io_cfg_valid  (io_cfg_valid),
    .io_cfg_data   (io_cfg_data),
    .io_cfg_ready  (io_cfg_ready),
    .io_d_out      (io_d_out),
    .io_configs_en (io_configs_en),
    .io_word_idx   (io_word_idx),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_error      (io_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    io_start = 1'b1;
    tick();
    io_start = 1'b0;
  endtask

  function automatic logic exp_error();
    logic [WW-1:0] x = '0;
    for (int i = 0; i < NW; i++) x = x ^ words[i];
    return (CHK != 0) && (x != words[NW]);
  endfunction

  // Runs one load from cycle 1 (first cycle after the io_start edge).
  // gaps: random valid gaps and event-based checking instead of exact timing.
  // abort_at > 0: at that cycle assert io_start (kind 0) or reset (kind 1) and return.
  task automatic run_load(input bit gaps, input int abort_at, input bit kind);
    int acc = 0;
    int nstrobe = 0;
    int gap = 0;
    int w;
    bit prev_en = 0;
    bit ready_c;
    bit fin = 0;
    logic [NW-1:0] e;
    for (int c = 1; c <= BUDGET && !fin; c++) begin
      if (!gaps) begin
        e = '0;
        if (c % 4 == 3 && c / 4 < NW) e = NW'(1) << (c / 4);
        check("en_timing", 64'(io_configs_en), 64'(e));
        check("ready_timing", 64'(io_cfg_ready),
              64'((c % 4 == 1 && c <= 4*NW - 3) || (CHK != 0 && c == 4*NW + 1)));
        check("done_timing", 64'(io_done), 64'(c >= 4*NW + 1 + CHK));
        check("busy_timing", 64'(io_busy), 64'(c < 4*NW + 1 + CHK));
        check("idx_timing", 64'(io_word_idx), 64'((c <= 4*NW) ? (c - 1) / 4 : NW - 1));
        if (c >= 2) begin
          w = (c - 2) / 4;
          if (w > NW - 1) w = NW - 1;
          check("dout_timing", 64'(io_d_out), 64'(words[w]));
        end
      end
      if (io_configs_en != '0) begin
        check("en_onehot", 64'(io_configs_en), 64'(NW'(1) << nstrobe));
        check("dout_at_strobe", 64'(io_d_out), 64'(words[nstrobe]));
        check("en_vs_ready", 64'(io_cfg_ready), 64'(0));
        check("en_back2back", 64'(prev_en), 64'(0));
        nstrobe++;
      end
      prev_en = |io_configs_en;
      if (io_done) fin = 1;
      if (!fin) begin
        io_cfg_valid = (gap == 0) && (acc <= NW - 1 + CHK);
        io_cfg_data  = (acc <= NW) ? words[acc] : '0;
        ready_c = io_cfg_ready;
        if (c == abort_at) begin
          if (kind) reset = 1'b1;
          else io_start = 1'b1;
          tick();
          reset = 1'b0;
          io_start = 1'b0;
          return;
        end
        tick();
        if (ready_c && io_cfg_valid) begin
          acc++;
          if (gaps) gap = $urandom_range(0, 5);
        end else if (gap > 0) begin
          gap--;
        end
      end
    end
    if (!fin) begin
      check("load_timeout", 64'(0), 64'(1));
      return;
    end
    check("strobe_count", 64'(nstrobe), 64'(NW));
    check("words_taken", 64'(acc), 64'(NW + CHK));
    check("error_flag", 64'(io_error), 64'(exp_error()));
    io_cfg_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("done_ready", 64'(io_cfg_ready), 64'(0));
      check("done_en", 64'(io_configs_en), 64'(0));
      check("done_sticky", 64'(io_done), 64'(1));
      check("done_busy", 64'(io_busy), 64'(0));
      check("done_dout", 64'(io_d_out), 64'(words[NW-1]));
    end
    io_cfg_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"},  64'(io_d_out),      64'(0));
    check({tag, "_en"},    64'(io_configs_en), 64'(0));
    check({tag, "_ready"}, 64'(io_cfg_ready),  64'(0));
    check({tag, "_idx"},   64'(io_word_idx),   64'(0));
    check({tag, "_busy"},  64'(io_busy),       64'(0));
    check({tag, "_done"},  64'(io_done),       64'(0));
    check({tag, "_error"}, 64'(io_error),      64'(0));
  endtask

  initial begin
    reset = 1'b1;
    io_start = 1'b0;
    io_cfg_valid = 1'b0;
    io_cfg_data = '0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    io_cfg_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_ready", 64'(io_cfg_ready), 64'(0));
      check("idle_busy", 64'(io_busy), 64'(0));
    end
    io_cfg_valid = 1'b0;

    // Incrementing words, checksum word is their XOR (zero for this set).
    for (int i = 0; i < NW; i++) words[i] = 32'h1000_0000 + 32'(i);
    words[NW] = 32'h0000_0000;
    pulse_start();
    run_load(1'b0, 0, 1'b0);

    // Random valid gaps.
    pulse_start();
    run_load(1'b1, 0, 1'b0);

    // Restart during the STROBE of word 10.
    pulse_start();
    run_load(1'b0, 43, 1'b0);
    check("restart_en", 64'(io_configs_en), 64'(0));
    check("restart_idx", 64'(io_word_idx), 64'(0));
    check("restart_done", 64'(io_done), 64'(0));
    check("restart_ready", 64'(io_cfg_ready), 64'(1));
    check("restart_busy", 64'(io_busy), 64'(1));
    run_load(1'b0, 0, 1'b0);

    // Restart in LOAD with a same-cycle transfer: that word is dropped.
    pulse_start();
    run_load(1'b0, 5, 1'b0);
    check("restart_load_idx", 64'(io_word_idx), 64'(0));
    run_load(1'b0, 0, 1'b0);

    // Reset during the HOLD of word 5.
    pulse_start();
    run_load(1'b0, 24, 1'b1);
    check_all_zero("midreset");
    io_cfg_valid = 1'b1;
    io_cfg_data = words[0];
    for (int k = 0; k < 8; k++) begin
      tick();
      check("postreset_ready", 64'(io_cfg_ready), 64'(0));
      check("postreset_busy", 64'(io_busy), 64'(0));
      check("postreset_dout", 64'(io_d_out), 64'(0));
      check("postreset_en", 64'(io_configs_en), 64'(0));
    end
    io_cfg_valid = 1'b0;
    pulse_start();
    run_load(1'b0, 0, 1'b0);

    // All-A5 words: matching checksum, then a bad one, then clear by io_start.
    for (int i = 0; i < NW; i++) words[i] = 32'hA5A5_A5A5;
    words[NW] = 32'h0000_0000;
    pulse_start();
    run_load(1'b0, 0, 1'b0);
    check("a5_good_error", 64'(io_error), 64'(0));
    words[NW] = 32'h0000_0001;
    pulse_start();
    run_load(1'b0, 0, 1'b0);
    check("a5_bad_error", 64'(io_error), 64'(CHK));
    pulse_start();
    check("error_cleared", 64'(io_error), 64'(0));
    check("done_cleared", 64'(io_done), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
